// File: rtl/alu_issue.sv
// alu_issue: two-stage operand-issue / result-capture front end for a 32-bit MIPS ALU
module alu_issue #(
   parameter bit TRAP_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_aluc,
   input  logic [31:0] alu_r,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_negative,
   input  logic        alu_overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_dest,
   output logic        out_wen,
   output logic        out_zero,
   output logic        out_carry,
   output logic        out_negative,
   output logic        out_overflow,
   output logic        out_trap,
   output logic        out_illegal,
   output logic [31:0] retire_cnt
);
   logic        d_valid, d_trap, d_carry, d_ill;
   logic [4:0]  d_dest;
   logic        r_free, accept, adv, trap;
   logic [5:0]  op, fn;
   logic [31:0] dec_a, dec_b;
   logic [3:0]  dec_aluc;
   logic [4:0]  dec_dest;
   logic        dec_trap, dec_carry, dec_ill, dec_shift;
   logic        unused_rs_field;

   assign op              = in_instr[31:26];
   assign fn              = in_instr[5:0];
   assign unused_rs_field = ^in_instr[25:21];
   assign r_free          = !out_valid || out_ready;
   assign in_ready        = !flush && (!d_valid || r_free);
   assign accept          = in_valid && in_ready;
   assign adv             = d_valid && r_free;
   assign trap            = d_trap && alu_overflow;

   // decode opcode/funct into ALU op, operand selection and per-op class bits
   always_comb begin
      dec_aluc  = 4'b0000;
      dec_ill   = 1'b0;
      dec_trap  = 1'b0;
      dec_carry = 1'b0;
      dec_shift = 1'b0;
      if (op == 6'h00) begin
         case (fn)
            6'h20: begin dec_aluc = 4'b0010; dec_trap = 1'b1; end
            6'h21: begin dec_aluc = 4'b0000; dec_carry = 1'b1; end
            6'h22: begin dec_aluc = 4'b0011; dec_trap = 1'b1; end
            6'h23: begin dec_aluc = 4'b0001; dec_carry = 1'b1; end
            6'h24: dec_aluc = 4'b0100;
            6'h25: dec_aluc = 4'b0101;
            6'h26: dec_aluc = 4'b0110;
            6'h27: dec_aluc = 4'b0111;
            6'h2A: dec_aluc = 4'b1011;
            6'h2B: begin dec_aluc = 4'b1010; dec_carry = 1'b1; end
            6'h00, 6'h04: begin dec_aluc = 4'b1110; dec_carry = 1'b1; dec_shift = 1'b1; end
            6'h02, 6'h06: begin dec_aluc = 4'b1101; dec_carry = 1'b1; dec_shift = 1'b1; end
            6'h03, 6'h07: begin dec_aluc = 4'b1100; dec_carry = 1'b1; dec_shift = 1'b1; end
            default: dec_ill = 1'b1;
         endcase
      end else begin
         case (op)
            6'h08: begin dec_aluc = 4'b0010; dec_trap = 1'b1; end
            6'h09: begin dec_aluc = 4'b0000; dec_carry = 1'b1; end
            6'h0A: dec_aluc = 4'b1011;
            6'h0B: begin dec_aluc = 4'b1010; dec_carry = 1'b1; end
            6'h0C: dec_aluc = 4'b0100;
            6'h0D: dec_aluc = 4'b0101;
            6'h0E: dec_aluc = 4'b0110;
            6'h0F: dec_aluc = 4'b1000;
            default: dec_ill = 1'b1;
         endcase
      end
      dec_dest = (op == 6'h00) ? in_instr[15:11] : in_instr[20:16];
      dec_a    = dec_ill ? 32'd0 :
                 dec_shift ? {27'd0, fn[2] ? in_rs_val[4:0] : in_instr[10:6]} : in_rs_val;
      dec_b    = dec_ill ? 32'd0 :
                 (op == 6'h00) ? in_rt_val :
                 op[2] ? {16'd0, in_instr[15:0]} : {{16{in_instr[15]}}, in_instr[15:0]};
   end

   // D stage: hold the ALU operands while the result stage is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_valid  <= 1'b0;
         alu_a    <= 32'd0;
         alu_b    <= 32'd0;
         alu_aluc <= 4'b0000;
         d_dest   <= 5'd0;
         d_trap   <= 1'b0;
         d_carry  <= 1'b0;
         d_ill    <= 1'b0;
      end else begin
         d_valid <= !flush && (accept || (d_valid && !r_free));
         if (accept) begin
            alu_a    <= dec_a;
            alu_b    <= dec_b;
            alu_aluc <= dec_aluc;
            d_dest   <= dec_dest;
            d_trap   <= dec_trap;
            d_carry  <= dec_carry;
            d_ill    <= dec_ill;
         end
      end
   end

   // R stage: capture masked ALU outputs and count retired results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_result   <= 32'd0;
         out_dest     <= 5'd0;
         out_wen      <= 1'b0;
         out_zero     <= 1'b0;
         out_carry    <= 1'b0;
         out_negative <= 1'b0;
         out_overflow <= 1'b0;
         out_trap     <= 1'b0;
         out_illegal  <= 1'b0;
         retire_cnt   <= 32'd0;
      end else begin
         out_valid <= !flush && (adv || (out_valid && !out_ready));
         if (adv) begin
            out_result   <= d_ill ? 32'd0 : alu_r;
            out_dest     <= d_dest;
            out_wen      <= !d_ill && (d_dest != 5'd0) && !(TRAP_EN && trap);
            out_zero     <= !d_ill && alu_zero;
            out_carry    <= d_carry && alu_carry;
            out_negative <= !d_ill && alu_negative;
            out_overflow <= trap;
            out_trap     <= trap;
            out_illegal  <= d_ill;
         end
         if (out_valid && out_ready) retire_cnt <= retire_cnt + 32'd1;
      end
   end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Operand-issue and result-capture front end for the 32-bit combinational ALU. It drives the ALU's a/b/aluc inputs and consumes its r/zero/carry/negative/overflow outputs.
- Accepts decoded-register-read MIPS ALU instructions over a valid/ready handshake and maps opcode/funct to aluc and operands.
- Registers the ALU outputs with per-op flag masking, overflow-trap and illegal-op detection, and presents the result to writeback over a second valid/ready handshake.
- Two-stage pipeline (D = issue, R = result), one instruction per cycle.

Parameters:
TRAP_EN, 1, 1: signed overflow on add/addi/sub suppresses out_wen; 0: overflow is flagged only.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous pipeline kill
in_valid  input  1  instruction/operands valid
in_ready  output  1  block accepts this cycle
in_instr  input  32  MIPS instruction word
in_rs_val  input  32  GPR[rs]
in_rt_val  input  32  GPR[rt]
alu_a  output  32  ALU operand a (shift amount for shifts)
alu_b  output  32  ALU operand b (shifted value for shifts)
alu_aluc  output  4  ALU op code
alu_r  input  32  ALU result
alu_zero, alu_carry, alu_negative, alu_overflow  input  1 each  ALU flags
out_valid  output  1  result valid
out_ready  input  1  writeback accepts
out_result  output  32  result (0 when illegal)
out_dest  output  5  destination register
out_wen  output  1  register write enable
out_zero, out_carry, out_negative, out_overflow  output  1 each  masked flags
out_trap  output  1  overflow trap taken
out_illegal  output  1  unsupported instruction
retire_cnt  output  32  count of out handshakes, wraps

Behaviour:
- Reset (async, rst=1): d_valid=0, out_valid=0, all out_* = 0, alu_a = alu_b = 0, alu_aluc = 4'b0000, retire_cnt = 0.
- Handshakes:
  - in_ready = !flush && (!d_valid || r_free), where r_free = !out_valid || out_ready.
  - Input accepted when in_valid && in_ready. An accepted instruction loads the D registers (alu_a, alu_b, alu_aluc, dest, class bits).
  - D advances to R when d_valid && r_free. R captures alu_r and flags that cycle.
- Latency: accept in cycle N gives out_valid in cycle N+2 when there is no backpressure. Full throughput is 1 per cycle.
- Stalls: while out_valid && !out_ready, all out_* hold stable. D also holds when stalled, and alu_* stay stable.
- Flush: d_valid and out_valid clear next edge and in_ready=0 that cycle. Flush beats a simultaneous out handshake: retire_cnt still increments if out_valid && out_ready in the flush cycle.
- R-type (opcode 0), dest = rd, funct → aluc:
  - add 0x20 → 0010, trap class
  - addu 0x21 → 0000
  - sub 0x22 → 0011, trap class
  - subu 0x23 → 0001
  - and 0x24 → 0100
  - or 0x25 → 0101
  - xor 0x26 → 0110
  - nor 0x27 → 0111
  - slt 0x2A → 1011
  - sltu 0x2B → 1010
  - sll 0x00 → 1110
  - srl 0x02 → 1101
  - sra 0x03 → 1100
  - sllv 0x04 → 1110
  - srlv 0x06 → 1101
  - srav 0x07 → 1100
- R-type operands:
  - Non-shift: a = rs_val, b = rt_val.
  - Fixed shifts: a = {27'b0, shamt}, b = rt_val.
  - Variable shifts: a = {27'b0, rs_val[4:0]}, b = rt_val.
- I-type, dest = rt, b = extended imm (SE = sign-extend, ZE = zero-extend), a = rs_val:
  - addi 0x08 → 0010, SE, trap class
  - addiu 0x09 → 0000, SE
  - slti 0x0A → 1011, SE
  - sltiu 0x0B → 1010, SE
  - andi 0x0C → 0100, ZE
  - ori 0x0D → 0101, ZE
  - xori 0x0E → 0110, ZE
  - lui 0x0F → 1000, ZE
- Any other opcode/funct is illegal: out_illegal=1, out_result=0, out_wen=0, all flags 0. The D stage drives aluc=0000 with a = b = 0.
- Flag masking at R:
  - out_zero and out_negative pass through for legal ops.
  - out_carry passes only for addu/addiu/subu/sltu/sltiu and all shifts, else 0.
  - out_overflow passes only for the trap class, else 0.
- Trap: out_trap = trap class && alu_overflow.
- Write enable: out_wen = legal && dest≠0 && !(TRAP_EN && out_trap).
- retire_cnt increments on each out_valid && out_ready and wraps 0xFFFFFFFF→0.
- Reset asserted mid-operation discards all in-flight instructions immediately.

Test Plan:
1. addu $3,$1,$2 with rs=0xFFFFFFFF, rt=0x00000001, out_ready=1 → 2 cycles later out_result=0, out_zero=1, out_carry=1, out_overflow=0, out_dest=3, out_wen=1.
2. add $4,$1,$2 with rs=0x7FFFFFFF, rt=1 → out_result=0x80000000, out_overflow=1, out_trap=1, out_wen=0. Repeat with TRAP_EN=0 → out_wen=1.
3. sra $5,$0,4 (shamt=4) with rt=0x80000010 → alu_a=4, alu_aluc=1100, out_result=0xF8000001, out_carry=0.
4. Stream 4 back-to-back instructions with out_ready held 0 for 3 cycles → in_ready drops after 2 accepted; out_* stable; no loss or duplication; retire_cnt=4 at end.
5. Opcode 0x23 (lw) → out_illegal=1, out_result=0, out_wen=0. Then addiu $0,$0,5 → out_wen=0 (dest 0), out_result=5.
6. Assert flush with both stages full and in_valid=1 → next cycle out_valid=0, input not accepted. Then assert rst async mid-stall → all outputs 0 without a clock edge.
